fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage and IF/ID pipeline latch for the pipelined MIPS core. Holds the PC and requests instructions from the icache over the iREN/ihit handshake. Presents the fetched word and its next-PC to the decode unit through a single-entry registered slot. Handles downstream stalls, control-flow redirects (including redirects that arrive while an icache access is outstanding) and halt.

## Interface
Parameters:
- PC_INIT, 32'h0000_0000, PC value loaded on reset.

Ports:
- CLK  in  1  core clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- iREN  out  1  icache read enable.
- iaddr  out  32 (word_t)  icache address; always equals pc.
- ihit  in  1  icache has returned iload for iaddr this cycle.
- iload  in  32 (word_t)  instruction word; valid only when ihit=1.
- stall  in  1  from hazard unit; decode cannot consume the IF/ID slot this cycle.
- redirect  in  1  control-flow change resolved downstream; implies flush.
- redirect_pc  in  32 (word_t)  target PC; bits [1:0] are ignored and forced to 0.
- halt_req  in  1  decode has a valid halt instruction in the slot.
- ifid_valid  out  1  IF/ID slot holds a live instruction.
- ifid_ins  out  32 (word_t)  instruction to decode (drives decode `ins`).
- ifid_npc  out  32 (word_t)  PC+4 of that instruction.

## Operation
- State machine, fetch_state_t: RUN, DRAIN, HALTED. Reset state is RUN.
- iREN = (state != HALTED) & !rst.
- accept = ihit & (!ifid_valid | !stall) & state==RUN & !redirect & !halt_req.
- **Accept:** on accept, the slot loads {iload, pc+4} with valid=1, and pc <= pc+4 (mod 2^32; wrap from 32'hFFFF_FFFC to 0).
- **Slot consumed:** if !stall and the slot is not reloaded that cycle, ifid_valid <= 0.
- **Stall:** if stall & ifid_valid, the slot holds unchanged. A coincident ihit is ignored, pc is unchanged, and the access repeats.
- **Redirect in RUN with ihit:** the fetched word is discarded, pc <= redirect_pc, ifid_valid <= 0, state stays RUN.
- **Redirect in RUN without ihit:** the access is outstanding, so iaddr must stay stable. pend_pc <= redirect_pc, ifid_valid <= 0, state -> DRAIN.
- **DRAIN:** iaddr is held at pc and the slot stays empty.
  - On ihit: the word is discarded, pc <= pend_pc, state -> RUN.
  - A new redirect overwrites pend_pc. If it coincides with ihit, the new target goes straight to pc.
  - halt_req is ignored.
- **Halt:** on halt_req & !redirect in RUN, state -> HALTED and pc is held.
  - A coincident ihit is discarded.
  - The halt instruction in the slot follows the normal consume/stall rules.
- **HALTED:** iREN=0 and nothing is fetched. A redirect (the halt was younger and squashed) sets pc <= redirect_pc, clears the slot, and returns to RUN.
- **Priority:** rst > redirect > halt_req > stall > ihit.
- **Reset values:** pc=PC_INIT, pend_pc=0, ifid_valid=0, ifid_ins=0, ifid_npc=0, iREN=0 during the reset cycle and 1 on the first cycle after.

## Timing
- ihit at cycle n with accept: ifid_valid/ifid_ins/ifid_npc update at edge n+1; iaddr advances to pc+4 at edge n+1.
- Minimum fetch-to-decode latency is 1 cycle. Throughput is 1 instruction per cycle when ihit stays high.
- Redirect at cycle n in RUN/HALTED: iaddr=redirect_pc from n+1.
- Redirect at cycle n in DRAIN: iaddr=target on the cycle after the outstanding ihit.
- No combinational path from ihit or iload to the slot outputs. iREN and iaddr depend only on state, pc and rst.

## Structure
- word_t comes from cpu_types_pkg.
- Add fetch_state_t (2-bit enum) and PC_STEP=4 to cpu_types_pkg so the hazard unit and testbench can reference them.
- One sub-module, ifid_latch: the slot register, with load, clear and hold controls, plus valid/ins/npc storage. fetch_unit instantiates it and owns the PC and FSM.

## Test plan
- **Reset:** hold rst 2 cycles with PC_INIT=32'h100 -> iREN=0 during reset, ifid_valid=0, ifid_ins=0, ifid_npc=0; then iREN=1, iaddr=32'h100.
- **Straight-line fetch:** ihit every 2nd cycle, stall=0 -> slot sequence npc 0x4, 0x8, 0xC; each ifid_valid pulse lasts 1 cycle; iaddr advances only after each hit.
- **Stall:** slot holds 0x8C00_0004 and stall=1 for 3 cycles with ihit=1 -> ifid_ins unchanged and iaddr constant; on the cycle stall drops, the next word loads.
- **Redirect during miss:** pc=0x20 with ihit=0, redirect to 0x400 -> state DRAIN, iaddr stays 0x20. When ihit arrives, that word never appears (ifid_valid stays 0) and iaddr becomes 0x400 next cycle.
- **Redirect coincident with ihit:** redirect to 0x80 plus ihit at pc=0x10 -> slot cleared, iaddr=0x80 next cycle, no DRAIN.
- **Halt then redirect:** halt_req with ihit=1 -> coincident word discarded, iREN=0 from the next cycle. Redirect to 0x200 two cycles later -> iREN=1 and iaddr=0x200 the cycle after.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg
// Shared types for the pipelined MIPS core: the machine word, the fetch
// stage state encoding, and the PC increment. The hazard unit and the
// fetch bench import this package so they agree on the encodings.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    // Fetch stage control states.
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam word_t PC_STEP = 32'd4;

    // Instruction addresses are word aligned, so the low two bits of any
    // externally supplied target are dropped.
    function automatic word_t align_word(input word_t addr);
        return addr & ~word_t'(32'h3);
    endfunction

endpackage

// File: rtl/ifid_latch.sv
// ifid_latch
// Single-entry IF/ID pipeline slot. Holds one fetched instruction and the
// PC+4 that goes with it, plus a valid flag.
// Ports:
//   CLK       core clock, rising edge
//   rst       synchronous active-high reset, zeroes the whole slot
//   load      capture load_ins/load_npc and mark the slot valid
//   clear     drop the slot contents (valid only; data is don't-care)
//   load_ins  instruction word to capture
//   load_npc  PC+4 of that instruction
//   valid     slot holds a live instruction
//   ins       stored instruction
//   npc       stored PC+4
module ifid_latch
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  rst,
    input  logic  load,
    input  logic  clear,
    input  word_t load_ins,
    input  word_t load_npc,
    output logic  valid,
    output word_t ins,
    output word_t npc
);

    // Load beats clear so a consumed slot can be refilled in the same
    // cycle; with neither asserted the slot simply holds.
    always_ff @(posedge CLK) begin
        if (rst) begin
            valid <= 1'b0;
            ins   <= '0;
            npc   <= '0;
        end else if (load) begin
            valid <= 1'b1;
            ins   <= load_ins;
            npc   <= load_npc;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction fetch stage of the pipelined MIPS core. Owns the PC and the
// fetch FSM, drives the icache read handshake, and feeds decode through an
// ifid_latch slot.
// Ports:
//   CLK, rst          clock and synchronous active-high reset
//   iREN, iaddr       icache read enable and address (iaddr is the PC)
//   ihit, iload       icache response and returned instruction word
//   stall             decode cannot consume the slot this cycle
//   redirect          downstream control-flow change, flushes the slot
//   redirect_pc       new PC; low two bits ignored
//   halt_req          decode holds a halt instruction
//   ifid_valid/ins/npc  IF/ID slot contents presented to decode
module fetch_unit
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
) (
    input  logic  CLK,
    input  logic  rst,
    output logic  iREN,
    output word_t iaddr,
    input  logic  ihit,
    input  word_t iload,
    input  logic  stall,
    input  logic  redirect,
    input  word_t redirect_pc,
    input  logic  halt_req,
    output logic  ifid_valid,
    output word_t ifid_ins,
    output word_t ifid_npc
);

    fetch_state_t state, state_next;
    word_t        pc, pc_next;
    word_t        pend_pc, pend_pc_next;
    word_t        target;
    word_t        pc_plus;
    logic         accept;
    logic         slot_load;
    logic         slot_clear;

    assign target  = align_word(redirect_pc);
    assign pc_plus = pc + PC_STEP;

    // The icache only ever sees the registered PC and state, so a redirect
    // cannot disturb an address that is already in flight.
    assign iREN  = (state != HALTED) && !rst;
    assign iaddr = pc;

    assign accept = ihit && (!ifid_valid || !stall) && (state == RUN)
                    && !redirect && !halt_req;

    // State, PC and the parked redirect target.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state   <= RUN;
            pc      <= PC_INIT;
            pend_pc <= '0;
        end else begin
            state   <= state_next;
            pc      <= pc_next;
            pend_pc <= pend_pc_next;
        end
    end

    // Next-state and slot control. Redirect outranks halt, which outranks
    // the normal stall/consume behaviour of the slot.
    always_comb begin
        state_next   = state;
        pc_next      = pc;
        pend_pc_next = pend_pc;
        slot_load    = 1'b0;
        slot_clear   = 1'b0;

        case (state)
            RUN: begin
                if (redirect) begin
                    slot_clear = 1'b1;
                    if (ihit) begin
                        pc_next = target;
                    end else begin
                        // The miss is still outstanding on iaddr; park the
                        // target until the icache answers.
                        pend_pc_next = target;
                        state_next   = DRAIN;
                    end
                end else if (halt_req) begin
                    state_next = HALTED;
                    slot_clear = !stall;
                end else if (accept) begin
                    slot_load = 1'b1;
                    pc_next   = pc_plus;
                end else begin
                    slot_clear = !stall;
                end
            end

            DRAIN: begin
                slot_clear = 1'b1;
                if (redirect) begin
                    if (ihit) begin
                        pc_next    = target;
                        state_next = RUN;
                    end else begin
                        pend_pc_next = target;
                    end
                end else if (ihit) begin
                    pc_next    = pend_pc;
                    state_next = RUN;
                end
            end

            HALTED: begin
                if (redirect) begin
                    // The halt was on a squashed path; resume at the target.
                    pc_next    = target;
                    slot_clear = 1'b1;
                    state_next = RUN;
                end else begin
                    slot_clear = !stall;
                end
            end

            default: begin
                state_next = RUN;
                slot_clear = 1'b1;
            end
        endcase
    end

    ifid_latch u_ifid (
        .CLK      (CLK),
        .rst      (rst),
        .load     (slot_load),
        .clear    (slot_clear),
        .load_ins (iload),
        .load_npc (pc_plus),
        .valid    (ifid_valid),
        .ins      (ifid_ins),
        .npc      (ifid_npc)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
// Directed vectors for fetch_unit. Each record gives the inputs held across
// one rising edge and the outputs expected just after that edge (inputs
// still applied). Slot data is compared whenever the slot is expected to be
// valid, and explicitly at reset.
module tb_fetch_unit;
    import cpu_types_pkg::*;

    localparam word_t PCI = 32'h0000_0100;

    logic  CLK;
    logic  rst;
    logic  iREN;
    word_t iaddr;
    logic  ihit;
    word_t iload;
    logic  stall;
    logic  redirect;
    word_t redirect_pc;
    logic  halt_req;
    logic  ifid_valid;
    word_t ifid_ins;
    word_t ifid_npc;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string name;
        logic  rst;
        logic  ihit;
        word_t iload;
        logic  stall;
        logic  redirect;
        word_t redirect_pc;
        logic  halt_req;
        logic  exp_iren;
        word_t exp_iaddr;
        logic  exp_valid;
        word_t exp_ins;
        word_t exp_npc;
        logic  chk_data;
    } vec_t;

    vec_t tbl[$];

    fetch_unit #(.PC_INIT(PCI)) dut (
        .CLK        (CLK),
        .rst        (rst),
        .iREN       (iREN),
        .iaddr      (iaddr),
        .ihit       (ihit),
        .iload      (iload),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .halt_req   (halt_req),
        .ifid_valid (ifid_valid),
        .ifid_ins   (ifid_ins),
        .ifid_npc   (ifid_npc)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic vec_t mk(string name, logic r, logic h, word_t ld,
                                logic s, logic rd, word_t rpc, logic hq,
                                logic eiren, word_t eaddr, logic evalid,
                                word_t eins, word_t enpc, logic chk);
        vec_t v;
        v.name = name;          v.rst = r;          v.ihit = h;
        v.iload = ld;           v.stall = s;        v.redirect = rd;
        v.redirect_pc = rpc;    v.halt_req = hq;    v.exp_iren = eiren;
        v.exp_iaddr = eaddr;    v.exp_valid = evalid;
        v.exp_ins = eins;       v.exp_npc = enpc;   v.chk_data = chk;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        rst         = v.rst;
        ihit        = v.ihit;
        iload       = v.iload;
        stall       = v.stall;
        redirect    = v.redirect;
        redirect_pc = v.redirect_pc;
        halt_req    = v.halt_req;
    endtask

    task automatic cmp(input string name, input string what,
                       input word_t act, input word_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s.%s actual=0x%08h expected=0x%08h",
                     name, what, act, exp);
        end
    endtask

    task automatic checkOutput(input vec_t v);
        cmp(v.name, "iREN",       word_t'(iREN),       word_t'(v.exp_iren));
        cmp(v.name, "iaddr",      iaddr,               v.exp_iaddr);
        cmp(v.name, "ifid_valid", word_t'(ifid_valid), word_t'(v.exp_valid));
        if (v.exp_valid || v.chk_data) begin
            cmp(v.name, "ifid_ins", ifid_ins, v.exp_ins);
            cmp(v.name, "ifid_npc", ifid_npc, v.exp_npc);
        end
    endtask

    task automatic runVec(input vec_t v);
        applyStimulus(v);
        @(posedge CLK);
        #1;
        checkOutput(v);
    endtask

    initial begin
        rst = 1'b1; ihit = 1'b0; iload = '0; stall = 1'b0;
        redirect = 1'b0; redirect_pc = '0; halt_req = 1'b0;

        // Reset, straight-line fetch and redirect coincident with ihit.
        //                 name        rst ih iload         st rd rpc           hq  iren iaddr         v  ins           npc           chk
        tbl.push_back(mk("rst0",      1, 0, 32'h0,        0, 0, 32'h0,        0,  0, PCI,          0, 32'h0,        32'h0,        1));
        tbl.push_back(mk("rst1",      1, 0, 32'h0,        0, 0, 32'h0,        0,  0, PCI,          0, 32'h0,        32'h0,        1));
        tbl.push_back(mk("out_rst",   0, 0, 32'h0,        0, 0, 32'h0,        0,  1, PCI,          0, 32'h0,        32'h0,        1));
        tbl.push_back(mk("to_zero",   0, 1, 32'hFFFF0000, 0, 1, 32'h0,        0,  1, 32'h0,        0, 32'h0,        32'h0,        0));
        tbl.push_back(mk("sl_wait0",  0, 0, 32'h0,        0, 0, 32'h0,        0,  1, 32'h0,        0, 32'h0,        32'h0,        0));
        tbl.push_back(mk("sl_hit0",   0, 1, 32'h11110000, 0, 0, 32'h0,        0,  1, 32'h4,        1, 32'h11110000, 32'h4,        0));
        tbl.push_back(mk("sl_wait1",  0, 0, 32'h0,        0, 0, 32'h0,        0,  1, 32'h4,        0, 32'h0,        32'h0,        0));
        tbl.push_back(mk("sl_hit1",   0, 1, 32'h22220004, 0, 0, 32'h0,        0,  1, 32'h8,        1, 32'h22220004, 32'h8,        0));
        tbl.push_back(mk("sl_wait2",  0, 0, 32'h0,        0, 0, 32'h0,        0,  1, 32'h8,        0, 32'h0,        32'h0,        0));
        tbl.push_back(mk("sl_hit2",   0, 1, 32'h33330008, 0, 0, 32'h0,        0,  1, 32'hC,        1, 32'h33330008, 32'hC,        0));
        tbl.push_back(mk("sl_wait3",  0, 0, 32'h0,        0, 0, 32'h0,        0,  1, 32'hC,        0, 32'h0,        32'h0,        0));
        tbl.push_back(mk("sl_hit3",   0, 1, 32'h4444000C, 0, 0, 32'h0,        0,  1, 32'h10,       1, 32'h4444000C, 32'h10,       0));
        tbl.push_back(mk("rc_redir",  0, 1, 32'hDEAD0010, 0, 1, 32'h80,       0,  1, 32'h80,       0, 32'h0,        32'h0,        0));
        tbl.push_back(mk("rc_idle",   0, 0, 32'h0,        0, 0, 32'h0,        0,  1, 32'h80,       0, 32'h0,        32'h0,        0));
        tbl.push_back(mk("rc_hit",    0, 1, 32'h55550080, 0, 0, 32'h0,        0,  1, 32'h84,       1, 32'h55550080, 32'h84,       0));

        foreach (tbl[i]) runVec(tbl[i]);

        // Stall with a held slot, then stall with an empty slot.
        runVec(mk("st_load",   0, 1, 32'h8C000004, 0, 0, 32'h0, 0, 1, 32'h88, 1, 32'h8C000004, 32'h88, 0));
        for (int k = 0; k < 3; k++)
            runVec(mk("st_hold", 0, 1, 32'h12345678, 1, 0, 32'h0, 0, 1, 32'h88, 1, 32'h8C000004, 32'h88, 0));
        runVec(mk("st_drop",   0, 1, 32'h12345678, 0, 0, 32'h0, 0, 1, 32'h8C, 1, 32'h12345678, 32'h8C, 0));
        runVec(mk("st_idle",   0, 0, 32'h0,        0, 0, 32'h0, 0, 1, 32'h8C, 0, 32'h0,        32'h0,  0));
        runVec(mk("st_empty",  0, 1, 32'hA5A5A5A5, 1, 0, 32'h0, 0, 1, 32'h90, 1, 32'hA5A5A5A5, 32'h90, 0));
        runVec(mk("st_idle2",  0, 0, 32'h0,        0, 0, 32'h0, 0, 1, 32'h90, 0, 32'h0,        32'h0,  0));

        // Redirect during a miss; low target bits dropped; DRAIN retarget.
        runVec(mk("dr_to20",   0, 1, 32'h0,        0, 1, 32'h20,  0, 1, 32'h20,  0, 32'h0,        32'h0,   0));
        runVec(mk("dr_redir",  0, 0, 32'h0,        0, 1, 32'h403, 0, 1, 32'h20,  0, 32'h0,        32'h0,   0));
        runVec(mk("dr_wait",   0, 0, 32'h0,        0, 0, 32'h0,   0, 1, 32'h20,  0, 32'h0,        32'h0,   0));
        runVec(mk("dr_hit",    0, 1, 32'hBAD0BAD0, 0, 0, 32'h0,   0, 1, 32'h400, 0, 32'h0,        32'h0,   0));
        runVec(mk("dr_run",    0, 1, 32'h66660400, 0, 0, 32'h0,   0, 1, 32'h404, 1, 32'h66660400, 32'h404, 0));
        runVec(mk("dr2_redir", 0, 0, 32'h0,        0, 1, 32'h600, 0, 1, 32'h404, 0, 32'h0,        32'h0,   0));
        runVec(mk("dr2_retgt", 0, 0, 32'h0,        0, 1, 32'h700, 0, 1, 32'h404, 0, 32'h0,        32'h0,   0));
        runVec(mk("dr2_hit",   0, 1, 32'hBAD1BAD1, 0, 0, 32'h0,   1, 1, 32'h700, 0, 32'h0,        32'h0,   0));
        runVec(mk("dr2_run",   0, 1, 32'h77770700, 0, 0, 32'h0,   0, 1, 32'h704, 1, 32'h77770700, 32'h704, 0));

        // Halt with coincident ihit, stay halted, then redirect out.
        runVec(mk("h_req",     0, 1, 32'hDEADBEEF, 0, 0, 32'h0,   1, 0, 32'h704, 0, 32'h0,        32'h0,   0));
        runVec(mk("h_idle",    0, 0, 32'h0,        0, 0, 32'h0,   0, 0, 32'h704, 0, 32'h0,        32'h0,   0));
        runVec(mk("h_hit",     0, 1, 32'hCAFECAFE, 0, 0, 32'h0,   0, 0, 32'h704, 0, 32'h0,        32'h0,   0));
        runVec(mk("h_redir",   0, 0, 32'h0,        0, 1, 32'h200, 0, 1, 32'h200, 0, 32'h0,        32'h0,   0));
        runVec(mk("h_run",     0, 1, 32'h88880200, 0, 0, 32'h0,   0, 1, 32'h204, 1, 32'h88880200, 32'h204, 0));
        runVec(mk("h2_stall",  0, 0, 32'h0,        1, 0, 32'h0,   1, 0, 32'h204, 1, 32'h88880200, 32'h204, 0));
        runVec(mk("h2_cons",   0, 0, 32'h0,        0, 0, 32'h0,   0, 0, 32'h204, 0, 32'h0,        32'h0,   0));
        runVec(mk("h2_redir",  0, 0, 32'h0,        0, 1, 32'h1000,0, 1, 32'h1000,0, 32'h0,        32'h0,   0));

        // PC wrap at the top of the address space, then reset mid-run.
        runVec(mk("w_top",     0, 1, 32'h0,        0, 1, 32'hFFFFFFFC, 0, 1, 32'hFFFFFFFC, 0, 32'h0, 32'h0, 0));
        runVec(mk("w_wrap",    0, 1, 32'h99999999, 0, 0, 32'h0,   0, 1, 32'h0,   1, 32'h99999999, 32'h0,   0));
        runVec(mk("w_rst",     1, 1, 32'h0,        0, 0, 32'h0,   0, 0, PCI,     0, 32'h0,        32'h0,   1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
